// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a first-word-fall-through circular buffer
// of {pc, instr} pairs with valid/ready on both sides and a single-cycle flush.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IW-1:0]              in_instr,
    input  logic [AW-1:0]              in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [IW-1:0]              out_instr,
    output logic [AW-1:0]              out_pc,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] instrmem [DEPTH];
    logic [AW-1:0] pcmem    [DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic          push;
    logic          pop;

    // Readiness comes from the registered count only, so a full queue never
    // accepts a beat in the same cycle that decode frees a slot.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_instr = out_valid ? instrmem[rp] : '0;
    assign out_pc    = out_valid ? pcmem[rp]    : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else if (flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instrmem[wp] <= in_instr;
            pcmem[wp]    <= in_pc;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: fill/drain, wrap streaming, full push/pop,
// flush, and asynchronous reset mid-operation.
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;

    int tests;
    int failed;

    if_id_queue #(.DEPTH(4), .IW(32), .AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(i * 4);
            in_instr = 32'(32'hA0 + i);
            tick();
            if (i == 0) begin
                check("fill_latency_valid", 32'(out_valid), 1);
                check("fill_latency_pc", out_pc, 32'h0);
            end
        end
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_head_pc", out_pc, 32'h0);
        check("full_head_instr", out_instr, 32'hA0);

        // Fifth beat offered while full is ignored
        in_pc    = 32'h10;
        in_instr = 32'hA4;
        tick();
        check("overfull_count", 32'(count), 4);
        check("overfull_head_pc", out_pc, 32'h0);

        // Drain in order
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", out_pc, 32'(i * 4));
            check("drain_instr", out_instr, 32'(32'hA0 + i));
            tick();
        end
        check("drained_valid", 32'(out_valid), 0);
        check("drained_instr", out_instr, 0);
        check("drained_pc", out_pc, 0);
        check("drained_count", 32'(count), 0);

        // Underflow attempt on empty queue
        tick();
        check("underflow_count", 32'(count), 0);
        check("underflow_valid", 32'(out_valid), 0);

        // Streaming across pointer wrap
        in_valid = 1'b1;
        in_pc    = 32'h100;
        in_instr = 32'hB0;
        tick();
        check("stream_first_count", 32'(count), 1);
        check("stream_first_pc", out_pc, 32'h100);
        for (int k = 1; k < 10; k++) begin
            in_pc    = 32'(32'h100 + 4 * k);
            in_instr = 32'(32'hB0 + k);
            tick();
            check("stream_count", 32'(count), 1);
            check("stream_pc", out_pc, 32'(32'h100 + 4 * k));
            check("stream_instr", out_instr, 32'(32'hB0 + k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_count", 32'(count), 0);

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pc    = 32'(32'h180 + 4 * i);
            in_instr = 32'(32'hC0 + i);
            tick();
        end
        check("pp_full_count", 32'(count), 4);
        in_pc     = 32'h190;
        in_instr  = 32'hC4;
        out_ready = 1'b1;
        tick();
        check("pp_count", 32'(count), 3);
        check("pp_in_ready", 32'(in_ready), 1);
        check("pp_head_pc", out_pc, 32'h184);

        // Flush mid-stream drops the concurrent beat
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h200;
        in_instr  = 32'hDD;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        check("flush_pc", out_pc, 0);
        out_ready = 1'b0;
        in_pc     = 32'h300;
        in_instr  = 32'hD0;
        tick();
        check("post_flush_pc", out_pc, 32'h300);
        check("post_flush_instr", out_instr, 32'hD0);
        check("post_flush_count", 32'(count), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_flush_drain", 32'(count), 0);
        out_ready = 1'b0;

        // Asynchronous reset between edges
        in_valid = 1'b1;
        in_pc    = 32'h400;
        in_instr = 32'hE0;
        tick();
        in_pc    = 32'h404;
        in_instr = 32'hE1;
        tick();
        in_valid = 1'b0;
        check("pre_arst_count", 32'(count), 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_valid", 32'(out_valid), 0);
        check("arst_pc", out_pc, 0);
        check("arst_in_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_pc    = 32'h500;
        in_instr = 32'hF0;
        tick();
        in_valid = 1'b0;
        check("post_arst_pc", out_pc, 32'h500);
        check("post_arst_instr", out_instr, 32'hF0);
        check("post_arst_count", 32'(count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
